// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the block state and round
// counter, drives an external combinational round datapath once per cycle
// and requests the matching round key from key expansion by index.
`timescale 1ns/1ps
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] pt_in,
  input  logic [DW-1:0] key_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ct_out,
  output logic          busy,
  output logic [DW-1:0] key_out,
  output logic [3:0]    rk_round,
  input  logic [DW-1:0] rk_in,
  output logic [DW-1:0] dp_state,
  output logic          dp_last,
  input  logic [DW-1:0] dp_result
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  localparam logic [3:0] NR_L = 4'(NR);

  fsm_e          fsm_q, fsm_d;
  logic [DW-1:0] state_q, state_d;
  logic [DW-1:0] key_q, key_d;
  logic [3:0]    round_q, round_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          dp_last_q, dp_last_d;
  logic          accept;

  // rk_in is consumed by the external datapath together with dp_state
  logic          unused_rk;
  assign unused_rk = ^rk_in;

  assign accept    = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ct_out    = state_q;
  assign key_out   = key_q;
  assign dp_state  = state_q;
  assign rk_round  = round_q;
  assign dp_last   = dp_last_q;

  // Next-state logic; handshake flags and dp_last are precomputed so every
  // output leaves a flop with no path from the host inputs.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    round_d     = round_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    dp_last_d   = dp_last_q;
    unique case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d    = pt_in ^ key_in;
          key_d      = key_in;
          round_d    = 4'd1;
          fsm_d      = ROUND;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          dp_last_d  = (NR_L == 4'd1);
        end
      end
      ROUND: begin
        state_d = dp_result;
        if (round_q == NR_L) begin
          fsm_d       = DONE;
          out_valid_d = 1'b1;
          dp_last_d   = 1'b0;
        end else begin
          round_d   = round_q + 4'd1;
          dp_last_d = ((round_q + 4'd1) == NR_L);
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d       = IDLE;
          out_valid_d = 1'b0;
          round_d     = '0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        fsm_d       = IDLE;
        round_d     = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        dp_last_d   = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dp_last_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      round_q     <= round_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      dp_last_q   <= dp_last_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: supplies a behavioural AES round datapath and key
// expansion, drives directed FIPS-197 vectors and scores ciphertexts,
// latency and per-cycle control outputs against hand-computed values.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

  localparam int NR = 10;

  localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] Z_CT   = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy, dp_last;
  logic [127:0] pt_in, key_in, ct_out, key_out, rk_in, dp_state, dp_result;
  logic [3:0]   rk_round;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [127:0] exp_q[$];

  aes_round_ctrl #(.NR(NR), .DW(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .pt_in(pt_in), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready), .ct_out(ct_out),
    .busy(busy), .key_out(key_out), .rk_round(rk_round), .rk_in(rk_in),
    .dp_state(dp_state), .dp_last(dp_last), .dp_result(dp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural AES environment ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_i, input logic [7:0] b_i);
    logic [7:0] a, b, p;
    a = a_i; b = b_i; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = '0;
    if (x != 8'h00)
      for (int i = 1; i < 256; i++)
        if (gmul(x, 8'(i)) == 8'h01) v = 8'(i);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input logic [3:0] n);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nn;
    nn = (n > 4'd10) ? 10 : int'(n);
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    rcon = 8'h01;
    for (int i = 4; i < 4*nn + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[7:0]), sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8])}
            ^ {24'h0, rcon};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*nn+3], w[4*nn+2], w[4*nn+1], w[4*nn]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   a[16], b[16], x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[8*i +: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r + 4*c] = a[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
      if (last) begin
        o[32*c +: 32] = {x3, x2, x1, x0};
      end else begin
        o[32*c      +: 8] = gmul(8'h02, x0) ^ gmul(8'h03, x1) ^ x2 ^ x3;
        o[32*c + 8  +: 8] = x0 ^ gmul(8'h02, x1) ^ gmul(8'h03, x2) ^ x3;
        o[32*c + 16 +: 8] = x0 ^ x1 ^ gmul(8'h02, x2) ^ gmul(8'h03, x3);
        o[32*c + 24 +: 8] = gmul(8'h03, x0) ^ x1 ^ x2 ^ gmul(8'h02, x3);
      end
    end
    return o ^ rk;
  endfunction

  assign rk_in     = round_key(key_out, rk_round);
  assign dp_result = aes_round(dp_state, rk_in, dp_last);

  // ---------------- checking ----------------
  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  int           acc_cyc = 0;
  int           hs_cyc  = -1;
  bit           exp_idle = 0;
  bit           prev_ov  = 0;
  logic [127:0] cur_exp  = '0;

  // Monitor: samples on the falling edge, pops the scoreboard on out_valid rise.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov  = 0;
        exp_idle = 0;
      end else begin
        if (exp_idle) begin
          chk("idle_after_hs_busy", 128'(busy), 128'(0));
          chk("idle_after_hs_in_ready", 128'(in_ready), 128'(1));
          exp_idle = 0;
        end
        if (in_valid && in_ready) begin
          acc_cyc = cyc;
          if (hs_cyc >= 0) chk("accept_after_hs", 128'(acc_cyc > hs_cyc), 128'(1));
        end
        if (busy && !out_valid) begin
          chk("rk_round_step", 128'(rk_round), 128'(cyc - acc_cyc));
          chk("dp_last", 128'(dp_last), 128'((cyc - acc_cyc) == NR));
          chk("round_in_ready", 128'(in_ready), 128'(0));
        end
        if (!busy) begin
          chk("idle_rk_round", 128'(rk_round), 128'(0));
          chk("idle_dp_last", 128'(dp_last), 128'(0));
          chk("idle_in_ready", 128'(in_ready), 128'(1));
          chk("idle_out_valid", 128'(out_valid), 128'(0));
        end
        if (out_valid && !prev_ov) begin
          chk("latency", 128'(cyc - acc_cyc), 128'(NR + 1));
          chk("scoreboard_nonempty", 128'(exp_q.size() != 0), 128'(1));
          if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
        end
        if (out_valid) begin
          chk("ct_out", ct_out, cur_exp);
          chk("done_in_ready", 128'(in_ready), 128'(0));
          chk("done_busy", 128'(busy), 128'(1));
          chk("done_dp_last", 128'(dp_last), 128'(0));
          if (out_ready) begin
            hs_cyc   = cyc;
            exp_idle = 1;
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c);
    bit got;
    @(posedge clk); #1;
    pt_in = p; key_in = k;
    exp_q.push_back(c);
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin n_tests++; n_fail++; $display("FAIL send_timeout: in_ready never high"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rnd) begin
        pt_in  = {$urandom, $urandom, $urandom, $urandom};
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!busy && !out_valid) begin got = 1; break; end
    end
    if (!got) begin n_tests++; n_fail++; $display("FAIL idle_timeout: busy=%0b out_valid=%0b", busy, out_valid); end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  128'(in_ready),  128'(1));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_busy"},      128'(busy),      128'(0));
    chk({tag, "_dp_last"},   128'(dp_last),   128'(0));
    chk({tag, "_rk_round"},  128'(rk_round),  128'(0));
    chk({tag, "_ct_out"},    ct_out,          128'(0));
    chk({tag, "_key_out"},   key_out,         128'(0));
  endtask

  initial begin
    bit got;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    pt_in = '0; key_in = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // FIPS-197 C.1 with the host always ready
    send(C1_PT, C1_KEY, C1_CT);
    wait_idle(0);

    // Host stalls for 20 cycles while offering another block
    out_ready = 1'b0;
    send(C1_PT, C1_KEY, C1_CT);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin got = 1; break; end
    end
    if (!got) begin n_tests++; n_fail++; $display("FAIL stall_wait: out_valid never high"); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      pt_in    = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle(0);

    // Back-to-back blocks
    send(C1_PT, C1_KEY, C1_CT);
    send('0, '0, Z_CT);
    wait_idle(0);

    // Asynchronous reset at round 5 discards the block
    send(C1_PT, C1_KEY, C1_CT);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rk_round == 4'd5) begin got = 1; break; end
    end
    if (!got) begin n_tests++; n_fail++; $display("FAIL reach_round5: rk_round=%0d", rk_round); end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    void'(exp_q.pop_back());
    @(posedge clk); #1 rst_n = 1'b1;
    send(C1_PT, C1_KEY, C1_CT);
    wait_idle(0);

    // Host inputs scrambled every cycle during the rounds
    send('0, '0, Z_CT);
    wait_idle(1);
    send(C1_PT, C1_KEY, C1_CT);
    wait_idle(1);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
